// File: rtl/fir_feeder_pkg.sv
// rtl/fir_feeder_pkg.sv - shared state encoding and packed weight-bus helpers for the FIR front end
package fir_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Low bit of tap slice idx on a packed bus of width-bit weights.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

    function automatic int unsigned tap_width(input int unsigned nb_taps);
        return (nb_taps > 1) ? $clog2(nb_taps) : 1;
    endfunction

endpackage

// File: rtl/fir_feeder_if.sv
// rtl/fir_feeder_if.sv - job control, weight/activation streams and FIR drive signals of fir_feeder
interface fir_feeder_if #(
    parameter int NB_TAPS      = 5,
    parameter int WEIGHT_WIDTH = 16,
    parameter int ACT_WIDTH    = 16,
    parameter int LEN_WIDTH    = 8
);
    logic                            start;
    logic                            reuse_w;
    logic [LEN_WIDTH-1:0]            row_len;
    logic                            w_valid;
    logic                            w_ready;
    logic [WEIGHT_WIDTH-1:0]         w_data;
    logic                            a_valid;
    logic                            a_ready;
    logic [ACT_WIDTH-1:0]            a_data;
    logic                            out_ready;
    logic [ACT_WIDTH-1:0]            fir_act;
    logic [WEIGHT_WIDTH*NB_TAPS-1:0] fir_wregs;
    logic                            fir_dff_en;
    logic                            fir_out_valid;
    logic                            busy;
    logic                            done;

    modport master (
        output start, reuse_w, row_len, w_valid, w_data, a_valid, a_data, out_ready,
        input  w_ready, a_ready, fir_act, fir_wregs, fir_dff_en, fir_out_valid, busy, done
    );

    modport slave (
        input  start, reuse_w, row_len, w_valid, w_data, a_valid, a_data, out_ready,
        output w_ready, a_ready, fir_act, fir_wregs, fir_dff_en, fir_out_valid, busy, done
    );

endinterface

// File: rtl/fir_feeder_wbank.sv
// rtl/fir_feeder_wbank.sv - NB_TAPS x WEIGHT_WIDTH weight register bank with per-slice write enable
module fir_wbank
    import fir_feeder_pkg::*;
#(
    parameter int NB_TAPS      = 5,
    parameter int WEIGHT_WIDTH = 16,
    parameter int TAP_W        = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            we,
    input  logic [TAP_W-1:0]                idx,
    input  logic [WEIGHT_WIDTH-1:0]         wdata,
    output logic [WEIGHT_WIDTH*NB_TAPS-1:0] wregs
);

    // Only the addressed slice changes, so an interrupted load keeps older taps intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wregs <= '0;
        end else begin
            for (int k = 0; k < NB_TAPS; k++) begin
                if (we && idx == TAP_W'(k)) begin
                    wregs[slice_lo(k, WEIGHT_WIDTH) +: WEIGHT_WIDTH] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/fir_feeder.sv
// rtl/fir_feeder.sv - loads FIR tap weights, streams one activation row and flags full-window outputs
module fir_feeder
    import fir_feeder_pkg::*;
#(
    parameter int NB_TAPS      = 5,
    parameter int WEIGHT_WIDTH = 16,
    parameter int ACT_WIDTH    = 16,
    parameter int LEN_WIDTH    = 8
) (
    input logic         clk,
    input logic         rst_n,
    fir_feeder_if.slave io
);

    localparam int TAP_W = tap_width(NB_TAPS);

    state_t               state;
    logic [TAP_W-1:0]     tap_cnt;
    logic [LEN_WIDTH-1:0] push_cnt;
    logic [LEN_WIDTH-1:0] len;
    logic                 w_ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 out_valid_q;

    logic                 beat;
    logic                 push;
    logic                 last_beat;
    logic                 last_push;
    logic [LEN_WIDTH:0]   push_next;

    assign beat      = io.w_valid && w_ready_q;
    assign push      = io.a_valid && io.a_ready;
    assign last_beat = (tap_cnt == TAP_W'(NB_TAPS - 1));
    assign push_next = {1'b0, push_cnt} + (LEN_WIDTH + 1)'(1);
    assign last_push = (push_next == {1'b0, len});

    // The FIR tap DFFs are the only act pipeline stage: acceptance drives their enable directly.
    assign io.a_ready       = (state == ST_STREAM) && io.out_ready;
    assign io.fir_dff_en    = push;
    assign io.fir_act       = io.a_data[ACT_WIDTH-1:0];
    assign io.w_ready       = w_ready_q;
    assign io.busy          = busy_q;
    assign io.done          = done_q;
    assign io.fir_out_valid = out_valid_q;

    fir_wbank #(
        .NB_TAPS      (NB_TAPS),
        .WEIGHT_WIDTH (WEIGHT_WIDTH),
        .TAP_W        (TAP_W)
    ) u_wbank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (beat),
        .idx   (tap_cnt),
        .wdata (io.w_data),
        .wregs (io.fir_wregs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            tap_cnt     <= '0;
            push_cnt    <= '0;
            len         <= '0;
            w_ready_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (io.start) begin
                        len    <= io.row_len;
                        busy_q <= 1'b1;
                        if (!io.reuse_w) begin
                            state     <= ST_LOAD_W;
                            tap_cnt   <= '0;
                            w_ready_q <= 1'b1;
                        end else if (io.row_len == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state    <= ST_STREAM;
                            push_cnt <= '0;
                        end
                    end
                end
                ST_LOAD_W: begin
                    if (beat) begin
                        if (last_beat) begin
                            tap_cnt   <= '0;
                            w_ready_q <= 1'b0;
                            if (len == '0) begin
                                state  <= ST_DONE;
                                done_q <= 1'b1;
                            end else begin
                                state    <= ST_STREAM;
                                push_cnt <= '0;
                            end
                        end else begin
                            tap_cnt <= tap_cnt + TAP_W'(1);
                        end
                    end
                end
                ST_STREAM: begin
                    if (push) begin
                        push_cnt <= push_next[LEN_WIDTH-1:0];
                        if (last_push) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            // The flag rises the cycle after the push completing a window, so stale chain data never shows valid.
            if (push) begin
                out_valid_q <= (push_next >= (LEN_WIDTH + 1)'(NB_TAPS));
            end else if (io.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_feeder.sv
// tb/tb_fir_feeder.sv - randomized directed bench for fir_feeder against a sliding-window FIR reference
module tb_fir_feeder;

    localparam int NB = 5;
    localparam int WW = 16;
    localparam int AW = 16;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fir_feeder_if #(.NB_TAPS(NB), .WEIGHT_WIDTH(WW), .ACT_WIDTH(AW), .LEN_WIDTH(LW)) io ();

    fir_feeder #(.NB_TAPS(NB), .WEIGHT_WIDTH(WW), .ACT_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    // Transposed-form FIR the feeder drives; chain[0] is its output register.
    longint chain [NB];
    always @(posedge clk) begin
        if (io.fir_dff_en) begin
            for (int k = 0; k < NB - 1; k++)
                chain[k] <= longint'(io.fir_wregs[k*WW +: WW]) * longint'(io.fir_act) + chain[k+1];
            chain[NB-1] <= longint'(io.fir_wregs[(NB-1)*WW +: WW]) * longint'(io.fir_act);
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [15:0] wq    [NB];
    logic [15:0] cur_w [NB];
    logic [15:0] acts  [$];
    longint      got   [$];
    longint      prev_p0;
    int          n_done, n_push, n_valid, done_cyc;
    bit          saw_wready, saw_aready, hold_prev, valid_at_done, w_acc, a_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic ready_for(input int mode);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            default: return $urandom_range(0, 2) != 0;
        endcase
    endfunction

    // One clock: sample at the falling edge, then leave inputs free to change just after the rising edge.
    task automatic tick();
        @(negedge clk);
        check("dff_en_eq_accept", io.fir_dff_en, io.a_valid && io.a_ready);
        check("a_ready_without_out_ready", io.a_ready && !io.out_ready, 0);
        if (io.fir_dff_en) begin
            check("act_passthrough", io.fir_act, io.a_data);
            n_push++;
        end
        if (hold_prev) begin
            check("hold_valid", io.fir_out_valid, 1);
            check("hold_value", chain[0], prev_p0);
        end
        hold_prev = io.fir_out_valid && !io.out_ready;
        prev_p0   = chain[0];
        if (io.w_ready) saw_wready = 1'b1;
        if (io.a_ready) saw_aready = 1'b1;
        if (io.fir_out_valid) n_valid++;
        if (io.fir_out_valid && io.out_ready) got.push_back(chain[0]);
        if (io.done) begin
            n_done++;
            done_cyc      = cyc;
            valid_at_done = io.fir_out_valid;
        end
        w_acc = io.w_valid && io.w_ready;
        a_acc = io.a_valid && io.a_ready;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input bit reuse, input int len, input int mode, input bit rand_valid);
        int     widx, aidx, guard, c0, exp_n;
        longint s;
        got.delete();
        n_done = 0; n_push = 0; n_valid = 0; done_cyc = 0;
        saw_wready = 0; saw_aready = 0; hold_prev = 0; valid_at_done = 0;
        c0 = cyc;
        io.start = 1'b1; io.reuse_w = reuse; io.row_len = LW'(len);
        io.out_ready = ready_for(mode);
        tick();
        io.start = 1'b0;
        check("busy_after_start", io.busy, 1);
        if (!reuse) begin
            widx = 0; guard = 0;
            while (widx < NB && guard < 200) begin
                io.w_valid   = ($urandom_range(0, 3) != 0);
                io.w_data    = wq[widx];
                io.out_ready = ready_for(mode);
                tick();
                if (w_acc) widx++;
                guard++;
            end
            io.w_valid = 1'b0;
            if (widx < NB) check("weight_load_timeout", widx, NB);
            for (int k = 0; k < NB; k++) cur_w[k] = wq[k];
        end
        aidx = 0; guard = 0;
        while (n_done == 0 && guard < 40 * len + 200) begin
            if (aidx < len) begin
                io.a_valid = !rand_valid || ($urandom_range(0, 3) != 0);
                io.a_data  = acts[aidx];
            end else begin
                io.a_valid = 1'b0;
                io.a_data  = '0;
            end
            io.out_ready = ready_for(mode);
            io.start     = ($urandom_range(0, 4) == 0);
            io.reuse_w   = 1'($urandom_range(0, 1));
            io.row_len   = LW'($urandom_range(0, 255));
            tick();
            if (a_acc) aidx++;
            guard++;
        end
        io.start = 1'b0; io.a_valid = 1'b0;
        if (n_done == 0) check("job_timeout", 0, 1);
        io.out_ready = 1'b1;
        tick();
        tick();
        check("busy_after_job", io.busy, 0);
        check("done_pulses", n_done, 1);
        check("push_count", n_push, len);
        check("w_ready_seen", saw_wready, !reuse);
        exp_n = (len >= NB) ? len - NB + 1 : 0;
        check("out_count", got.size(), exp_n);
        for (int j = 0; j < exp_n; j++) begin
            s = 0;
            for (int t = 0; t < NB; t++) s += longint'(cur_w[NB-1-t]) * longint'(acts[j+t]);
            if (j < got.size()) check("out_value", got[j], s);
        end
        if (len >= NB) check("valid_with_done", valid_at_done, 1);
        else           check("no_valid_short_row", n_valid, 0);
        if (len == 0 && reuse) begin
            check("zero_len_latency", done_cyc - c0, 1);
            check("zero_len_no_a_ready", saw_aready, 0);
        end
        for (int k = 0; k < NB; k++) check("wregs_slice", io.fir_wregs[k*WW +: WW], cur_w[k]);
    endtask

    task automatic fill_random_acts(input int n);
        acts.delete();
        for (int i = 0; i < n; i++) acts.push_back(16'($urandom));
    endtask

    initial begin
        int len;
        rst_n = 1'b0;
        io.start = 0; io.reuse_w = 0; io.row_len = '0; io.w_valid = 0; io.w_data = '0;
        io.a_valid = 0; io.a_data = '0; io.out_ready = 1'b1;
        for (int k = 0; k < NB; k++) cur_w[k] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", io.busy, 0);
        check("rst_done", io.done, 0);
        check("rst_wregs", io.fir_wregs, 0);
        check("rst_out_valid", io.fir_out_valid, 0);
        check("rst_w_ready", io.w_ready, 0);
        check("rst_a_ready", io.a_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < NB; k++) wq[k] = 16'(k + 1);
        acts.delete();
        for (int i = 0; i < 7; i++) acts.push_back(16'(i + 1));
        run_job(0, 7, 0, 0);
        if (got.size() == 3) begin
            check("rowA_out0", got[0], 35);
            check("rowA_out1", got[1], 50);
            check("rowA_out2", got[2], 65);
        end

        run_job(0, 7, 1, 0);
        if (got.size() == 3) begin
            check("rowB_out0", got[0], 35);
            check("rowB_out1", got[1], 50);
            check("rowB_out2", got[2], 65);
        end

        acts.delete();
        for (int i = 0; i < 6; i++) acts.push_back(16'd10);
        run_job(1, 6, 0, 1);
        if (got.size() > 0) check("reuse_first_out", got[0], 150);

        fill_random_acts(3);
        run_job(1, 3, 2, 1);

        run_job(1, 0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NB; k++) wq[k] = 16'($urandom);
            len = $urandom_range(0, 20);
            fill_random_acts(len);
            run_job(1'($urandom_range(0, 1)), len, $urandom_range(0, 2), 1);
        end

        for (int k = 0; k < NB; k++) wq[k] = 16'($urandom);
        fill_random_acts(255);
        run_job(0, 255, 2, 1);

        for (int k = 0; k < NB; k++) wq[k] = 16'(k + 100);
        io.start = 1'b1; io.reuse_w = 1'b0; io.row_len = LW'(10);
        tick();
        io.start = 1'b0;
        for (int k = 0; k < NB; k++) begin
            io.w_valid = 1'b1; io.w_data = wq[k];
            tick();
        end
        io.w_valid = 1'b0; io.out_ready = 1'b1; io.a_valid = 1'b1; io.a_data = 16'd7;
        tick();
        tick();
        io.a_valid = 1'b0;
        check("mid_job_busy", io.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wregs", io.fir_wregs, 0);
        check("async_rst_busy", io.busy, 0);
        check("async_rst_done", io.done, 0);
        check("async_rst_out_valid", io.fir_out_valid, 0);
        check("async_rst_w_ready", io.w_ready, 0);
        check("async_rst_a_ready", io.a_ready, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NB; k++) cur_w[k] = '0;

        fill_random_acts(8);
        run_job(1, 8, 0, 1);

        for (int k = 0; k < NB; k++) wq[k] = 16'($urandom);
        fill_random_acts(12);
        run_job(0, 12, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_feeder.md
Name: fir_feeder

Overview:
- Front-end sequencer for the transposed-form FIR tap chain.
- Receives a serial weight stream and latches NB_TAPS weights into the packed weight bus.
- Then streams one row of activations into the FIR, driving its enable in lock-step with each accepted activation.
- Flags which FIR outputs carry a full NB_TAPS-term window, so the downstream collector ignores warm-up partial sums.

Parameters:
- NB_TAPS, 5: number of FIR taps / weights per kernel row.
- WEIGHT_WIDTH, 16: bits per weight.
- ACT_WIDTH, 16: bits per activation.
- LEN_WIDTH, 8: width of the row-length field.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin a row job; sampled only in IDLE.
- reuse_w, input, 1: sampled with start; 1 = skip weight load and keep current weights.
- row_len, input, LEN_WIDTH: activations in the row; sampled with start.
- w_valid, input, 1: weight beat valid.
- w_ready, output, 1: weight beat accepted when w_valid && w_ready.
- w_data, input, WEIGHT_WIDTH: weight beat. Beat k goes to tap k.
- a_valid, input, 1: activation valid.
- a_ready, output, 1: activation accepted when a_valid && a_ready.
- a_data, input, ACT_WIDTH: activation.
- out_ready, input, 1: downstream can take a FIR output this cycle.
- fir_act, output, ACT_WIDTH: to FIR act input.
- fir_wregs, output, WEIGHT_WIDTH*NB_TAPS: to FIR weight bus. Tap k occupies bits [(k+1)*WEIGHT_WIDTH-1 : k*WEIGHT_WIDTH].
- fir_dff_en, output, 1: to FIR DFF enable.
- fir_out_valid, output, 1: FIR output register currently holds a full-window result.
- busy, output, 1: state != IDLE.
- done, output, 1: one-cycle pulse at job end.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All of the following clear to 0: state (IDLE), fir_wregs, fir_out_valid, done, tap counter, push counter, latched length.
- States and transitions:
  - IDLE: start && reuse_w=0 -> LOAD_W. start && reuse_w=1 -> STREAM, or -> DONE if row_len==0.
  - LOAD_W -> STREAM after the NB_TAPS-th accepted beat, or -> DONE if the latched length is 0.
  - STREAM -> DONE on the push that makes push_cnt == len.
  - DONE -> IDLE after exactly 1 cycle. done=1 only in DONE.
- Sampling: start is ignored outside IDLE. row_len and reuse_w are latched on the start cycle.
- Weight load:
  - w_ready = (state==LOAD_W).
  - Beat k writes only slice k of fir_wregs. The tap counter wraps to 0 on exit.
  - Weights stay stable through STREAM and until the next LOAD_W.
  - A partial load retains the already-written slices. The remaining slices keep their old values until written.
- Streaming:
  - a_ready = (state==STREAM) && out_ready.
  - fir_act = a_data, combinational pass-through.
  - fir_dff_en = a_valid && a_ready, combinational, same cycle as acceptance.
  - No internal act buffering; the FIR tap DFFs are the only pipeline stage.
- Push counter: push_cnt counts accepted activations. It clears on entry to STREAM.
- Output validity (registered):
  - On a push, fir_out_valid <= (push_cnt+1 >= NB_TAPS).
  - Otherwise, if out_ready, fir_out_valid <= 0.
  - Otherwise it holds.
  - Effect: the FIR output register is flagged valid the cycle after the push that completes a full window, so stale chain contents from the previous row are never flagged.
- Output count: a row of length L yields max(0, L-NB_TAPS+1) valid outputs.
- Latency: the last valid output is presented in the same cycle as done.
- Backpressure: while out_ready=0, no push occurs and fir_out_valid/Fir_out hold. No output is lost or duplicated.
- Boundary conditions:
  - row_len < NB_TAPS: all acts are consumed, no valid outputs are produced, done still pulses.
  - row_len == 2^LEN_WIDTH-1 is legal.
  - The push counter is LEN_WIDTH bits and never wraps within a row.
- Reset mid-job: returns to IDLE immediately and clears fir_wregs. The next job must reload weights; reuse_w=1 after reset streams with zero weights, which is legal.

Decomposition:
- Shared package: state encoding (IDLE, LOAD_W, STREAM, DONE) and the slice-index helper for packed weight buses, shared with the FIR wrapper.
- No sub-module is required. The weight register bank may optionally be its own block, fir_wbank (NB_TAPS x WEIGHT_WIDTH, per-slice write enable).

Test Plan:
- Weights 1,2,3,4,5 (beats 0..4), row_len=7, acts 1..7, out_ready=1 -> fir_wregs slice k = k+1. Exactly 3 valid outputs, in order 35,50,65 (i.e. 5*a[n-4] + … + 1*a[n] against a reference FIR model). done on the cycle the 3rd is valid.
- Same job, with out_ready toggled 1,0,0,1 repeatedly -> a_ready tracks out_ready. fir_dff_en is never 1 while out_ready=0. Same 3 values, each held while out_ready=0.
- Back-to-back rows with reuse_w=1, row 2 acts all 10 -> no LOAD_W visit. First valid output of row 2 is 150, with no row-1 residue flagged.
- row_len=3 (< NB_TAPS) -> 3 fir_dff_en pulses, fir_out_valid never 1, done pulses once.
- row_len=0 with reuse_w=1 -> IDLE, DONE, IDLE in 2 cycles. No a_ready.
- rst_n low during STREAM after 2 pushes -> all outputs 0 asynchronously. A new start with reuse_w=0 reloads and runs correctly. start pulses while busy are ignored.
